// File: rtl/clyde_sb_layer_seq_pkg.sv
// Shared constants for the Clyde S-box layer sequencer: S-box latency and
// the round-controller state encoding.
package clyde_sb_layer_seq_pkg;

    // Pipeline depth of the masked dual Spook S-box, in enabled cycles
    localparam int SPOOK_SBOX_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sb_state_e;

endpackage

// File: rtl/clyde_sb_layer_seq_tag_pipe.sv
// LAT-deep enabled shift register of {valid, idx} tags; it advances only
// when the gadget it shadows is enabled, so tags stay aligned with the data.
module MSKsb_tag_pipe #(
    parameter int LAT = 2,
    parameter int W   = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         valid_i,
    input  logic [W-1:0] idx_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);

    logic         valid_q [LAT];
    logic [W-1:0] idx_q   [LAT];

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q[gi] <= 1'b0;
                    idx_q[gi]   <= '0;
                end else if (en_i) begin
                    if (gi == 0) begin
                        valid_q[gi] <= valid_i;
                        idx_q[gi]   <= idx_i;
                    end else begin
                        valid_q[gi] <= valid_q[gi-1];
                        idx_q[gi]   <= idx_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign valid_o = valid_q[LAT-1];
    assign idx_o   = idx_q[LAT-1];

endmodule

// File: rtl/clyde_sb_layer_seq.sv
// Issue/retire sequencer for the masked dual S-box: streams NCOL columns in
// order, paced on randomness, and tags which column leaves the S-box.
module clyde_sb_layer_seq
    import clyde_sb_layer_seq_pkg::*;
#(
    parameter int d    = 4,
    parameter int NCOL = 32,
    parameter int LAT  = SPOOK_SBOX_LAT,
    parameter int CW   = $clog2(NCOL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          inverse,
    output logic          busy,
    output logic          done,
    input  logic          rnd_valid,
    output logic          rnd_ready,
    output logic          sb_enable,
    output logic          sb_inverse,
    output logic          col_valid,
    output logic [CW-1:0] col_idx,
    output logic          wb_valid,
    output logic [CW-1:0] wb_col
);

    localparam int CNTW = CW + 1;
    localparam logic [CNTW-1:0] LAST_COL = CNTW'(NCOL - 1);

    generate
        if (d < 1 || LAT < 1 || LAT != SPOOK_SBOX_LAT) begin : g_bad_cfg
            $error("clyde_sb_layer_seq: invalid share count or S-box latency");
        end
    endgenerate

    sb_state_e       state_q, state_d;
    logic [CNTW-1:0] issue_q, issue_d;
    logic [CNTW-1:0] retire_q, retire_d;
    logic            inv_q, inv_d;
    logic            tail_valid;
    logic [CW-1:0]   tail_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            issue_q  <= '0;
            retire_q <= '0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            issue_q  <= issue_d;
            retire_q <= retire_d;
            inv_q    <= inv_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        issue_d  = issue_q;
        retire_d = retire_q;
        inv_d    = inv_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    issue_d  = '0;
                    retire_d = '0;
                    inv_d    = inverse;
                end
            end
            ST_RUN: begin
                if (col_valid) begin
                    issue_d = issue_q + 1'b1;
                    if (issue_q == LAST_COL) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wb_valid && retire_q == LAST_COL) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Retirements can already happen in RUN once LAT columns are in flight
        if (wb_valid) retire_d = retire_q + 1'b1;
    end

    always_comb begin
        busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done       = (state_q == ST_DONE);
        sb_enable  = busy && rnd_valid;
        rnd_ready  = sb_enable;
        sb_inverse = inv_q;
        col_valid  = (state_q == ST_RUN) && rnd_valid;
        col_idx    = issue_q[CW-1:0];
        wb_valid   = tail_valid && sb_enable;
        wb_col     = tail_idx;
    end

    MSKsb_tag_pipe #(
        .LAT (LAT),
        .W   (CW)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .en_i    (sb_enable),
        .valid_i (col_valid),
        .idx_i   (col_idx),
        .valid_o (tail_valid),
        .idx_o   (tail_idx)
    );

endmodule

// File: tb/tb_clyde_sb_layer_seq.sv
// Directed bench for clyde_sb_layer_seq: nominal, stalled, start-while-busy,
// async reset mid-layer and back-to-back layers.
module tb_clyde_sb_layer_seq;

    localparam int NCOL = 32;
    localparam int LAT  = 2;
    localparam int CW   = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          inverse;
    logic          busy;
    logic          done;
    logic          rnd_valid;
    logic          rnd_ready;
    logic          sb_enable;
    logic          sb_inverse;
    logic          col_valid;
    logic [CW-1:0] col_idx;
    logic          wb_valid;
    logic [CW-1:0] wb_col;

    int n_vec = 0;
    int n_err = 0;
    logic prev_inv = 1'b0;

    always #5 clk = ~clk;

    clyde_sb_layer_seq #(.d(4), .NCOL(NCOL), .LAT(LAT), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .inverse    (inverse),
        .busy       (busy),
        .done       (done),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .sb_enable  (sb_enable),
        .sb_inverse (sb_inverse),
        .col_valid  (col_valid),
        .col_idx    (col_idx),
        .wb_valid   (wb_valid),
        .wb_col     (wb_col)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {busy, done, rnd_ready, sb_enable, sb_inverse, col_valid, col_idx, wb_valid, wb_col};
    // indices are zeroed when their valid is low
    function automatic logic [31:0] pack_obs();
        logic [CW-1:0] ci;
        logic [CW-1:0] wc;
        ci = col_valid ? col_idx : '0;
        wc = wb_valid ? wb_col : '0;
        return {16'h0, busy, done, rnd_ready, sb_enable, sb_inverse, col_valid, ci, wb_valid, wc};
    endfunction

    // Runs one layer from its IDLE start cycle (cycle 0) through its done cycle.
    // Expected outputs come from counting enabled cycles: enabled cycle e issues
    // column e (while e < NCOL) and writes back column e-LAT (once e >= LAT).
    task automatic run_layer(input string tag, input logic inv_mode, input logic [63:0] stall_mask,
                             input int busy_start_cyc, input int exp_done_cyc);
        int e = 0;
        int n_wb = 0;
        int n_rnd = 0;
        int dut_done_cyc = -1;
        int next_wb = 0;
        bit model_done = 0;
        for (int c = 0; c < 70 && !model_done; c++) begin
            logic act, en, cv, wv, dn, inv_e;
            logic [CW-1:0] ci, wc;
            start     = (c == 0) || (c == busy_start_cyc);
            inverse   = (c == 0) ? inv_mode : ~inv_mode;
            rnd_valid = ~stall_mask[c];
            #1;
            act   = (c >= 1) && (e < NCOL + LAT);
            dn    = (c >= 1) && (e == NCOL + LAT);
            en    = act && rnd_valid;
            cv    = en && (e < NCOL);
            wv    = en && (e >= LAT);
            ci    = cv ? CW'(e) : '0;
            wc    = wv ? CW'(e - LAT) : '0;
            inv_e = (c == 0) ? prev_inv : inv_mode;
            check_eq($sformatf("%s c%0d", tag, c), pack_obs(),
                     {16'h0, act, dn, en, en, inv_e, cv, ci, wv, wc});
            if (wb_valid) begin
                if (wb_col == CW'(next_wb)) next_wb++;
                n_wb++;
            end
            if (rnd_ready) n_rnd++;
            if (done && dut_done_cyc < 0) dut_done_cyc = c;
            if (en) e++;
            if (dn) model_done = 1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_eq({tag, " done_cyc"}, dut_done_cyc, exp_done_cyc);
        check_eq({tag, " wb_count"}, n_wb, 32);
        check_eq({tag, " wb_in_order"}, next_wb, 32);
        check_eq({tag, " rnd_words"}, n_rnd, 34);
        $display("layer %s inv=%0d: done at %0d, %0d write-backs, %0d rnd words", tag, inv_mode, dut_done_cyc, n_wb, n_rnd);
        prev_inv = inv_mode;
    endtask

    initial begin
        int dcyc [2];
        int wbn  [2];
        int rndn [2];
        int nd;

        rst = 1'b1; start = 1'b0; inverse = 1'b0; rnd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset outputs", pack_obs(), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("idle after reset", pack_obs(), 32'h0);

        run_layer("nominal", 1'b0, 64'h0, -1, 35);
        run_layer("stalls", 1'b1, (64'h1 << 5) | (64'h1 << 6) | (64'h1 << 33), -1, 38);
        run_layer("start_busy", 1'b1, 64'h0, 10, 35);

        // Async reset in the middle of an inverse layer
        start = 1'b1; inverse = 1'b1; rnd_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check_eq("async reset mid-layer", pack_obs(), 32'h0);
        $display("reset mid-layer: outputs %h", pack_obs());
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        prev_inv = 1'b0;
        run_layer("after_reset", 1'b0, 64'h0, -1, 35);

        // Back-to-back: IDLE + 34 RUN/DRAIN + DONE per layer, start held high
        nd = 0;
        dcyc = '{-1, -1}; wbn = '{0, 0}; rndn = '{0, 0};
        start = 1'b1; inverse = 1'b0; rnd_valid = 1'b1;
        for (int c = 0; c < 72; c++) begin
            #1;
            if (nd < 2) begin
                if (wb_valid) wbn[nd]++;
                if (rnd_ready) rndn[nd]++;
                if (done) begin
                    dcyc[nd] = c;
                    nd++;
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        for (int l = 0; l < 2; l++) begin
            check_eq($sformatf("b2b L%0d done_cyc", l), dcyc[l], (l == 0) ? 35 : 71);
            check_eq($sformatf("b2b L%0d wb_count", l), wbn[l], 32);
            check_eq($sformatf("b2b L%0d rnd_words", l), rndn[l], 34);
            $display("b2b layer %0d: done at %0d, %0d write-backs, %0d rnd words", l, dcyc[l], wbn[l], rndn[l]);
        end
        @(posedge clk); #1;
        check_eq("idle after b2b", pack_obs(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
